ahb_spi_master: RTL and testbench
=================================

// Module: ahb_spi_master
//
// PURPOSE
//   AHB-lite single-register SPI master (mode 0, MSB first) that sits at the
//   SPI address, directly downstream of the AHB slave mux. It consumes the
//   data-phase select SPI_SEL plus the muxed HWRITE/HWDATA, runs one 8-bit
//   full-duplex transfer per write, and returns status plus receive data on
//   HRDATA_SPI. Zero-wait-state: HRDATA_SPI is valid in the data phase.
//
// PARAMETERS
//   CLK_DIV   4   SCK half-period in HCLK cycles; legal range >= 1
//                 (1 gives SCK = HCLK/2)
//
// PORTS
//   HCLK        in   1   system clock; all logic on its rising edge
//   HRESETn     in   1   asynchronous, active-low reset
//   SPI_SEL     in   1   data-phase select for the SPI address (registered by the mux)
//   HWRITE      in   1   muxed AHB write control, address phase
//   HWDATA      in   32  muxed AHB write data, data phase; only [7:0] used
//   HRDATA_SPI  out  32  {21'b0, ovr, rxv, busy, rx_data[7:0]}
//   SPI_SCK     out  1   serial clock, idle low
//   SPI_MOSI    out  1   serial data out
//   SPI_MISO    in   1   serial data in
//   SPI_CS_N    out  1   chip select, active low
//   SPI_IRQ     out  1   one-cycle pulse when a transfer completes
//
// BEHAVIOUR
//   Reset values: SCK=0, MOSI=0, CS_N=1, IRQ=0, busy=0, rxv=0, ovr=0,
//     rx_data=0, hwrite_q=0, FSM=IDLE, divider=0.
//   Bus decode
//   - hwrite_q <= HWRITE on every cycle, so it holds the write flag of the
//     transfer now in its data phase.
//   - wr = SPI_SEL & hwrite_q; rd = SPI_SEL & ~hwrite_q.
//   - HRDATA_SPI is combinational from the registers and always driven.
//   Write
//   - wr while busy=0: load tx shift register with HWDATA[7:0]; FSM -> SETUP.
//   - wr while busy=1: data ignored; ovr <= 1.
//   Read
//   - rd returns the current register values.
//   - On the following edge, rxv <= 0 and ovr <= 0.
//   FSM (divider counts CLK_DIV HCLK cycles per state step)
//   - IDLE: CS_N=1, SCK=0, busy=0.
//   - SETUP: entered on the accepting edge.
//     - CS_N=0, busy=1, MOSI=tx[7].
//     - After one half-period: SHIFT.
//   - SHIFT: 16 half-periods; SCK toggles at each half-period boundary.
//     - Rising SCK: sample MISO into rx shift LSB.
//     - Falling SCK: shift tx; MOSI = next bit.
//     - Ends with SCK low after the 8th falling edge: HOLD.
//   - HOLD: one half-period with CS_N=0. On exit:
//     - CS_N=1, busy=0, rx_data <= rx shift, rxv <= 1, IRQ=1 for one cycle.
//     - FSM -> IDLE.
//   - busy is high for 18*CLK_DIV cycles in total.
//   Simultaneous events and boundaries
//   - Completion and rd in the same cycle: the read sees the old rx_data and
//     rxv; set wins, so afterwards rxv=1 with the new data.
//   - Completion and wr in the same cycle: busy is still 1, so the write is
//     ignored and ovr <= 1.
//   - Completion while rxv=1: rx_data is overwritten and ovr <= 1.
//   - Set beats clear for both rxv and ovr.
//   - Back-to-back transfers: a write accepted in IDLE the cycle after
//     completion starts normally.
//   - HRESETn low mid-transfer: immediately returns all reset values;
//     CS_N deasserts asynchronously.
//
// TESTING (CLK_DIV=2, MISO looped to MOSI unless stated)
//   1. Write 0xA5 -> CS_N low for 36 cycles; MOSI bits 1,0,1,0,0,1,0,1 on
//      SCK rising edges; one IRQ pulse; then read = 0x0000_02A5, and a
//      second read = 0x0000_00A5.
//   2. MISO tied high, write 0x00 -> read after IRQ = 0x0000_02FF.
//   3. Write 0x11, then write 0x22 at cycle 10 -> 0x22 ignored;
//      rx_data=0x11; read = 0x0000_0611 (ovr=1); ovr=0 afterwards.
//   4. Read issued in the exact IRQ cycle -> returns 0x0000_0100 (busy=1,
//      old data); the next read returns 0x0000_02xx.
//   5. Assert HRESETn low at cycle 15 of a transfer -> CS_N=1, SCK=0,
//      HRDATA_SPI=0 immediately; a new write 0x3C completes normally.
//   6. CLK_DIV=1: write 0x5A -> SCK period 2 HCLK cycles; busy 18 cycles;
//      rx_data=0x5A.

Source files
------------

// File: rtl/ahb_spi_master.sv
// ahb_spi_master
//   Single-register AHB-lite SPI master (mode 0, MSB first). Each accepted
//   write runs one 8-bit full-duplex transfer. Reads return status and the
//   last received byte with zero wait states.
//
// Parameters
//   CLK_DIV     SCK half-period in HCLK cycles (>= 1)
//
// Ports
//   HCLK        system clock, rising edge
//   HRESETn     asynchronous active-low reset
//   SPI_SEL     data-phase select for this slave
//   HWRITE      address-phase write flag (muxed)
//   HWDATA      data-phase write data, only [7:0] used
//   HRDATA_SPI  {21'b0, ovr, rxv, busy, rx_data[7:0]}
//   SPI_SCK     serial clock, idle low
//   SPI_MOSI    serial data out
//   SPI_MISO    serial data in
//   SPI_CS_N    chip select, active low
//   SPI_IRQ     one-cycle pulse in the last busy cycle of a transfer
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | CS_N high, SCK low, waiting for a write
// ST_SETUP | CS_N low, first MOSI bit presented, one half-period
// ST_SHIFT | 16 half-periods, SCK toggles at the end of each one
// ST_HOLD  | SCK low, CS_N still low, one half-period; exit completes

module ahb_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        SPI_SEL,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA_SPI,
  output logic        SPI_SCK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  output logic        SPI_CS_N,
  output logic        SPI_IRQ
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       hp_q;
  logic [7:0]       tx_q;
  logic [7:0]       rx_sh_q;
  logic [7:0]       rx_data_q;
  logic             sck_q;
  logic             rxv_q;
  logic             ovr_q;
  logic             hwrite_q;

  logic wr, rd, tick, busy, cs_n, done, accept;

  logic unused_hwdata;
  assign unused_hwdata = ^HWDATA[31:8];

  assign wr     = SPI_SEL & hwrite_q;
  assign rd     = SPI_SEL & ~hwrite_q;
  assign tick   = (div_q == '0);
  assign accept = wr & ~busy;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    cs_n    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        cs_n = 1'b1;
        if (wr) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick && hp_q == 4'd0) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (tick) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        busy    = 1'b0;
        cs_n    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Divider reloads on acceptance and on every terminal count, so each
  // state step lasts exactly CLK_DIV cycles.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hwrite_q <= 1'b0;
      div_q    <= '0;
      hp_q     <= 4'd0;
      tx_q     <= 8'h00;
      rx_sh_q  <= 8'h00;
      sck_q    <= 1'b0;
    end else begin
      hwrite_q <= HWRITE;
      if (accept) begin
        div_q <= DIV_LOAD;
        tx_q  <= HWDATA[7:0];
      end else if (busy) begin
        div_q <= tick ? DIV_LOAD : div_q - 1'b1;
      end
      if (state_q == ST_SETUP && tick) hp_q <= 4'd15;
      // SCK toggles at the end of each shift half-period; the 16th toggle
      // (the 8th falling edge) coincides with entry into HOLD.
      if (state_q == ST_SHIFT && tick) begin
        hp_q  <= hp_q - 4'd1;
        sck_q <= ~sck_q;
        if (!sck_q) rx_sh_q <= {rx_sh_q[6:0], SPI_MISO};
        else        tx_q    <= {tx_q[6:0], 1'b0};
      end
    end
  end

  // Status flags: set has priority over the read-clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_data_q <= 8'h00;
      rxv_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (done) rx_data_q <= rx_sh_q;
      if (done)    rxv_q <= 1'b1;
      else if (rd) rxv_q <= 1'b0;
      if ((wr && busy) || (done && rxv_q)) ovr_q <= 1'b1;
      else if (rd)                         ovr_q <= 1'b0;
    end
  end

  assign HRDATA_SPI = {21'b0, ovr_q, rxv_q, busy, rx_data_q};
  assign SPI_SCK    = sck_q;
  assign SPI_MOSI   = tx_q[7];
  assign SPI_CS_N   = cs_n;
  assign SPI_IRQ    = done;

endmodule

// File: tb/tb_ahb_spi_master.sv
module tb_ahb_spi_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = 32'h0;
  logic        sel0 = 1'b0;
  logic        sel1 = 1'b0;
  logic        miso_high = 1'b0;

  logic [31:0] hr0, hr1;
  logic        sck0, mosi0, csn0, irq0, miso0;
  logic        sck1, mosi1, csn1, irq1;

  assign miso0 = miso_high ? 1'b1 : mosi0;

  always #5 HCLK = ~HCLK;

  ahb_spi_master #(.CLK_DIV(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .SPI_SEL(sel0), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HRDATA_SPI(hr0), .SPI_SCK(sck0), .SPI_MOSI(mosi0),
    .SPI_MISO(miso0), .SPI_CS_N(csn0), .SPI_IRQ(irq0)
  );

  ahb_spi_master #(.CLK_DIV(1)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .SPI_SEL(sel1), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HRDATA_SPI(hr1), .SPI_SCK(sck1), .SPI_MOSI(mosi1),
    .SPI_MISO(mosi1), .SPI_CS_N(csn1), .SPI_IRQ(irq1)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level reference for the CLK_DIV=2 instance: a transfer is a
  // countdown of 36 busy cycles, the last of which is the completion cycle.
  int         m_left;
  logic [7:0] m_rx, m_pend;
  logic       m_rxv, m_ovr, m_hwq;

  logic [31:0] o_hr, o_hr1, e_hr;
  logic        o_sck, o_mosi, o_csn, o_irq, o_sck1, o_irq1;
  logic        e_irq, e_csn;

  task automatic model_reset();
    m_left = 0; m_rx = 8'h00; m_pend = 8'h00;
    m_rxv = 1'b0; m_ovr = 1'b0; m_hwq = 1'b0;
  endtask

  task automatic cyc(input logic s0, input logic s1, input logic hw, input logic [31:0] d);
    logic wr, rd, done, n_rxv, n_ovr;
    logic [7:0] n_rx;
    int n_left;
    sel0 = s0; sel1 = s1; HWRITE = hw; HWDATA = d;
    @(negedge HCLK);
    o_hr = hr0; o_sck = sck0; o_mosi = mosi0; o_csn = csn0; o_irq = irq0;
    o_hr1 = hr1; o_sck1 = sck1; o_irq1 = irq1;
    e_hr  = {21'b0, m_ovr, m_rxv, (m_left > 0), m_rx};
    e_irq = (m_left == 1);
    e_csn = (m_left == 0);
    wr = s0 & m_hwq;
    rd = s0 & ~m_hwq;
    done = (m_left == 1);
    n_left = (m_left > 0) ? m_left - 1 : 0;
    n_rxv = m_rxv; n_ovr = m_ovr; n_rx = m_rx;
    if (rd) begin n_rxv = 1'b0; n_ovr = 1'b0; end
    if (wr && m_left > 0) n_ovr = 1'b1;
    if (wr && m_left == 0) begin
      n_left = 36;
      m_pend = miso_high ? 8'hFF : d[7:0];
    end
    if (done) begin
      n_rx = m_pend; n_rxv = 1'b1;
      if (m_rxv) n_ovr = 1'b1;
    end
    m_left = n_left; m_rx = n_rx; m_rxv = n_rxv; m_ovr = n_ovr; m_hwq = hw;
    @(posedge HCLK); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic tgt);
    cyc(1'b0, 1'b0, 1'b1, 32'h0);
    cyc(~tgt, tgt, 1'b0, {24'($urandom()), b});
  endtask

  task automatic rd_op(input logic tgt);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(~tgt, tgt, 1'b0, 32'h0);
  endtask

  task automatic pulse_reset();
    HRESETn = 1'b0; #2; HRESETn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    idle();
    checks++;
    if (o_hr !== 32'h0 || o_csn !== 1'b1 || o_sck !== 1'b0 || o_mosi !== 1'b0 || o_irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: hr=%h csn=%b sck=%b mosi=%b irq=%b, required hr=0 csn=1 sck=0 mosi=0 irq=0",
               o_hr, o_csn, o_sck, o_mosi, o_irq);
    end
    checks++;
    if (o_hr1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_state_div1: hr=%h required 00000000", o_hr1);
    end
  endtask

  task automatic test_transfer(input logic [7:0] b);
    logic [7:0] bits;
    logic       prev_sck;
    int nb, csn_low, irqs;
    wr_byte(b, 1'b0);
    checks++;
    if (o_hr !== e_hr) begin
      failures++;
      $display("FAIL xfer_write_phase: hr=%h required %h", o_hr, e_hr);
    end
    prev_sck = o_sck; bits = 8'h00; nb = 0; csn_low = 0; irqs = 0;
    for (int i = 0; i < 38; i++) begin
      idle();
      checks++;
      if (o_hr !== e_hr || o_irq !== e_irq || o_csn !== e_csn) begin
        failures++;
        $display("FAIL xfer_cycle%0d: hr=%h irq=%b csn=%b required hr=%h irq=%b csn=%b",
                 i, o_hr, o_irq, o_csn, e_hr, e_irq, e_csn);
      end
      if (o_csn === 1'b0) csn_low++;
      if (o_irq === 1'b1) irqs++;
      if (prev_sck === 1'b0 && o_sck === 1'b1) begin
        if (nb < 8) bits[3'(7 - nb)] = o_mosi;
        nb++;
      end
      prev_sck = o_sck;
    end
    checks++;
    if (csn_low != 36) begin failures++; $display("FAIL xfer_csn_low: %0d cycles, required 36", csn_low); end
    checks++;
    if (irqs != 1) begin failures++; $display("FAIL xfer_irq_count: %0d, required 1", irqs); end
    checks++;
    if (nb != 8 || bits !== b) begin
      failures++;
      $display("FAIL xfer_mosi_bits: %0d rises bits=%h, required 8 rises bits=%h", nb, bits, b);
    end
    rd_op(1'b0);
    checks++;
    if (o_hr !== (32'h200 | {24'h0, b}) || o_hr !== e_hr) begin
      failures++;
      $display("FAIL xfer_read1: hr=%h required %h", o_hr, 32'h200 | {24'h0, b});
    end
    rd_op(1'b0);
    checks++;
    if (o_hr !== {24'h0, b} || o_hr !== e_hr) begin
      failures++;
      $display("FAIL xfer_read2: hr=%h required %h", o_hr, {24'h0, b});
    end
  endtask

  task automatic test_miso_high();
    miso_high = 1'b1;
    wr_byte(8'h00, 1'b0);
    repeat (38) idle();
    miso_high = 1'b0;
    rd_op(1'b0);
    checks++;
    if (o_hr !== 32'h2FF || o_hr !== e_hr) begin
      failures++;
      $display("FAIL miso_high_read: hr=%h required 000002ff", o_hr);
    end
  endtask

  task automatic test_overrun();
    wr_byte(8'h11, 1'b0);
    repeat (6) idle();
    wr_byte(8'h22, 1'b0);
    checks++;
    if (o_hr !== e_hr || o_hr[8] !== 1'b1) begin
      failures++;
      $display("FAIL ovr_write_busy: hr=%h required %h", o_hr, e_hr);
    end
    for (int i = 0; i < 32; i++) begin
      idle();
      checks++;
      if (o_hr !== e_hr) begin
        failures++;
        $display("FAIL ovr_cycle%0d: hr=%h required %h", i, o_hr, e_hr);
      end
    end
    rd_op(1'b0);
    checks++;
    if (o_hr !== 32'h611 || o_hr !== e_hr) begin
      failures++;
      $display("FAIL ovr_read1: hr=%h required 00000611", o_hr);
    end
    rd_op(1'b0);
    checks++;
    if (o_hr !== 32'h011 || o_hr !== e_hr) begin
      failures++;
      $display("FAIL ovr_read2: hr=%h required 00000011", o_hr);
    end
  endtask

  task automatic test_read_at_irq();
    logic [7:0] b;
    b = 8'($urandom());
    pulse_reset();
    wr_byte(b, 1'b0);
    repeat (34) idle();
    rd_op(1'b0);
    checks++;
    if (o_irq !== 1'b1 || o_hr !== 32'h100 || o_hr !== e_hr) begin
      failures++;
      $display("FAIL irq_cycle_read: irq=%b hr=%h required irq=1 hr=00000100", o_irq, o_hr);
    end
    rd_op(1'b0);
    checks++;
    if (o_hr !== (32'h200 | {24'h0, b}) || o_hr !== e_hr) begin
      failures++;
      $display("FAIL irq_next_read: hr=%h required %h", o_hr, 32'h200 | {24'h0, b});
    end
  endtask

  task automatic test_reset_mid();
    wr_byte(8'($urandom()), 1'b0);
    repeat (13) idle();
    HRESETn = 1'b0;
    #1;
    checks++;
    if (csn0 !== 1'b1 || sck0 !== 1'b0 || hr0 !== 32'h0 || irq0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: csn=%b sck=%b hr=%h irq=%b required csn=1 sck=0 hr=0 irq=0",
               csn0, sck0, hr0, irq0);
    end
    #2;
    HRESETn = 1'b1;
    model_reset();
    wr_byte(8'h3C, 1'b0);
    repeat (38) idle();
    rd_op(1'b0);
    checks++;
    if (o_hr !== 32'h23C || o_hr !== e_hr) begin
      failures++;
      $display("FAIL reset_mid_recover: hr=%h required 0000023c", o_hr);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1, b2;
    b1 = 8'($urandom()); b2 = 8'($urandom());
    wr_byte(b1, 1'b0);
    repeat (35) idle();
    cyc(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (o_irq !== 1'b1) begin failures++; $display("FAIL b2b_irq: irq=%b required 1", o_irq); end
    cyc(1'b1, 1'b0, 1'b0, {24'h0, b2});
    checks++;
    if (o_hr !== (32'h200 | {24'h0, b1})) begin
      failures++;
      $display("FAIL b2b_write_phase: hr=%h required %h", o_hr, 32'h200 | {24'h0, b1});
    end
    for (int i = 0; i < 37; i++) begin
      idle();
      checks++;
      if (o_hr !== e_hr || o_irq !== e_irq || o_csn !== e_csn) begin
        failures++;
        $display("FAIL b2b_cycle%0d: hr=%h irq=%b csn=%b required hr=%h irq=%b csn=%b",
                 i, o_hr, o_irq, o_csn, e_hr, e_irq, e_csn);
      end
    end
    rd_op(1'b0);
    checks++;
    if (o_hr !== (32'h600 | {24'h0, b2}) || o_hr !== e_hr) begin
      failures++;
      $display("FAIL b2b_read: hr=%h required %h", o_hr, 32'h600 | {24'h0, b2});
    end
  endtask

  task automatic test_div1();
    int busy_cnt, rises, irqs, last_rise, bad_gap;
    logic prev_sck;
    wr_byte(8'h5A, 1'b1);
    busy_cnt = 0; rises = 0; irqs = 0; last_rise = -1; bad_gap = 0;
    prev_sck = o_sck1;
    for (int i = 0; i < 24; i++) begin
      idle();
      if (o_hr1[8] === 1'b1) busy_cnt++;
      if (o_irq1 === 1'b1) irqs++;
      if (prev_sck === 1'b0 && o_sck1 === 1'b1) begin
        if (last_rise >= 0 && i - last_rise != 2) bad_gap++;
        last_rise = i;
        rises++;
      end
      prev_sck = o_sck1;
    end
    checks++;
    if (busy_cnt != 18) begin failures++; $display("FAIL div1_busy: %0d cycles, required 18", busy_cnt); end
    checks++;
    if (rises != 8 || bad_gap != 0) begin
      failures++;
      $display("FAIL div1_sck: %0d rises %0d bad periods, required 8 rises 0 bad", rises, bad_gap);
    end
    checks++;
    if (irqs != 1) begin failures++; $display("FAIL div1_irq: %0d, required 1", irqs); end
    rd_op(1'b1);
    checks++;
    if (o_hr1 !== 32'h25A) begin
      failures++;
      $display("FAIL div1_read: hr=%h required 0000025a", o_hr1);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    test_reset();
    test_transfer(8'hA5);
    for (int k = 0; k < 3; k++) test_transfer(8'($urandom()));
    test_miso_high();
    test_overrun();
    test_read_at_irq();
    test_reset_mid();
    test_back_to_back();
    test_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
